// File: rtl/lbm_stream_sched.sv
// Streaming-step scheduler for the D2Q9 LBM core: walks every (cell, direction)
// and issues (source, destination, direction) requests with periodic wrap.
module lbm_stream_sched #(
  parameter int NX = 8,
  parameter int NY = 8,
  parameter int Q  = 9,
  parameter int AW = $clog2(NX*NY)
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [32*Q-1:0] CX,
  input  logic [32*Q-1:0] CY,
  output logic            Req_Valid,
  input  logic            Req_Ready,
  output logic [AW-1:0]   Src_Cell,
  output logic [AW-1:0]   Dst_Cell,
  output logic [3:0]      Dir,
  output logic            Busy,
  output logic            Done
);

  localparam int XW = (NX > 1) ? $clog2(NX) : 1;
  localparam int YW = (NY > 1) ? $clog2(NY) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, ISSUE, FINISH} state_t;

  state_t state, state_nx;

  logic [XW-1:0]    x_q, x_nx, px, dx;
  logic [YW-1:0]    y_q, y_nx, py, dy;
  logic [3:0]       d_q, d_nx, pd;
  logic signed [1:0] ox_q [Q];
  logic signed [1:0] oy_q [Q];
  logic signed [1:0] ox_dec [Q];
  logic signed [1:0] oy_dec [Q];
  logic signed [1:0] pox, poy;
  logic             hs, last_dir, last_x, last_y;
  logic [AW-1:0]    src_c, dst_c;

  // Only the integer byte's sign matters; fraction bits are consumed here
  // purely so they are not reported as dangling inputs.
  logic frac_unused;
  assign frac_unused = ^{CX, CY};

  function automatic logic signed [1:0] sgn(input logic [7:0] b);
    if (b == 8'd0)  return 2'b00;
    else if (b[7])  return 2'b11;
    else            return 2'b01;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < Q; i++) begin
      ox_dec[i] = sgn(CX[32*i+24 +: 8]);
      oy_dec[i] = sgn(CY[32*i+24 +: 8]);
    end
  end

  assign hs       = (state == ISSUE) && Req_Ready;
  assign last_dir = (d_q == 4'(Q-1));
  assign last_x   = (x_q == XW'(NX-1));
  assign last_y   = (y_q == YW'(NY-1));

  // Payload is registered one step ahead: in LOAD it is built for (0,0,0)
  // from the offsets being latched, otherwise for the post-handshake position.
  always_comb begin
    d_nx = last_dir ? '0 : d_q + 4'd1;
    x_nx = last_dir ? (last_x ? '0 : x_q + 1'b1) : x_q;
    y_nx = (last_dir && last_x) ? (last_y ? '0 : y_q + 1'b1) : y_q;
    if (state == LOAD) begin
      px  = '0;
      py  = '0;
      pd  = '0;
      pox = ox_dec[0];
      poy = oy_dec[0];
    end else begin
      px  = x_nx;
      py  = y_nx;
      pd  = d_nx;
      pox = ox_q[pd];
      poy = oy_q[pd];
    end
    case (pox)
      2'b01:   dx = (px == XW'(NX-1)) ? '0 : px + 1'b1;
      2'b11:   dx = (px == '0) ? XW'(NX-1) : px - 1'b1;
      default: dx = px;
    endcase
    case (poy)
      2'b01:   dy = (py == YW'(NY-1)) ? '0 : py + 1'b1;
      2'b11:   dy = (py == '0) ? YW'(NY-1) : py - 1'b1;
      default: dy = py;
    endcase
    src_c = AW'(py) * AW'(NX) + AW'(px);
    dst_c = AW'(dy) * AW'(NX) + AW'(dx);
  end

  always_comb begin
    state_nx  = state;
    Req_Valid = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE:   if (Start) state_nx = LOAD;
      LOAD: begin
        Busy     = 1'b1;
        state_nx = ISSUE;
      end
      ISSUE: begin
        Busy      = 1'b1;
        Req_Valid = 1'b1;
        if (hs && last_dir && last_x && last_y) state_nx = FINISH;
      end
      FINISH: begin
        Done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      d_q      <= '0;
      Src_Cell <= '0;
      Dst_Cell <= '0;
      Dir      <= '0;
      for (int unsigned i = 0; i < Q; i++) begin
        ox_q[i] <= '0;
        oy_q[i] <= '0;
      end
    end else begin
      state <= state_nx;
      if (state == LOAD) begin
        for (int unsigned i = 0; i < Q; i++) begin
          ox_q[i] <= ox_dec[i];
          oy_q[i] <= oy_dec[i];
        end
        x_q <= '0;
        y_q <= '0;
        d_q <= '0;
      end else if (hs) begin
        x_q <= x_nx;
        y_q <= y_nx;
        d_q <= d_nx;
      end
      if (state == LOAD || hs) begin
        Src_Cell <= src_c;
        Dst_Cell <= dst_c;
        Dir      <= pd;
      end
    end
  end

endmodule
